// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready push into a FIFO, LSB-first serialiser with gapless frames.
// Optional parity stage and parity_odd port are enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int DATA_WIDTH      = 8,
  parameter int STOP_BITS       = 1,
  parameter int COUNT_WIDTH     = 11,
  parameter int COUNT_MAX       = 1084,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [DATA_WIDTH-1:0]    in,
  input  logic                     valid,
  output logic                     ready,
  output logic                     out,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] level
`ifdef UART_TX_PARITY_EN
  ,
  input  logic                     parity_odd
`endif
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [COUNT_WIDTH-1:0]   CNT_LAST   = COUNT_WIDTH'(COUNT_MAX);
  localparam logic [2:0]               DATA_LAST  = 3'(DATA_WIDTH - 1);
  localparam logic [2:0]               STOP_LAST  = 3'(STOP_BITS - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] LEVEL_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                     state_reg, state_next;
  logic [COUNT_WIDTH-1:0]     cnt_reg, cnt_next;
  logic [2:0]                 bit_reg, bit_next;
  logic [DATA_WIDTH-1:0]      shift_reg, shift_next;
  logic                       out_reg, out_next;
  logic                       par_reg;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_DEPTH_LOG2:0]   level_reg, level_next;
  logic [DATA_WIDTH-1:0]      mem [DEPTH];

  logic tick, empty, push, pop;

  assign tick  = (cnt_reg == CNT_LAST);
  assign empty = (level_reg == '0);
  assign ready = (level_reg != LEVEL_FULL);
  assign push  = valid && ready;
  assign out   = out_reg;
  assign busy  = (state_reg != S_IDLE) || !empty;
  assign level = level_reg;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_reg] <= in;
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = (state_reg == S_IDLE) ? '0 : cnt_reg + 1'b1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    out_next   = out_reg;
    pop        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        out_next = 1'b1;
        pop      = !empty;
      end
      S_START: begin
        if (tick) begin
          state_next = S_DATA;
          cnt_next   = '0;
          bit_next   = '0;
          out_next   = shift_reg[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_next   = '0;
          shift_next = shift_reg >> 1;
          if (bit_reg == DATA_LAST) begin
            bit_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
            out_next   = par_reg;
`else
            state_next = S_STOP;
            out_next   = 1'b1;
`endif
          end else begin
            bit_next = bit_reg + 1'b1;
            out_next = shift_reg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          state_next = S_STOP;
          cnt_next   = '0;
          bit_next   = '0;
          out_next   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          cnt_next = '0;
          if (bit_reg == STOP_LAST) begin
            // Chain straight into the next frame when data is waiting.
            pop        = !empty;
            state_next = S_IDLE;
            out_next   = 1'b1;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        out_next   = 1'b1;
      end
    endcase
    if (pop) begin
      state_next = S_START;
      cnt_next   = '0;
      bit_next   = '0;
      out_next   = 1'b0;
    end
  end

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      out_reg    <= 1'b1;
      par_reg    <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      out_reg   <= out_next;
      level_reg <= level_next;
      if (pop) begin
        shift_reg <= mem[rd_ptr_reg];
`ifdef UART_TX_PARITY_EN
        par_reg   <= (^mem[rd_ptr_reg]) ^ parity_odd;
`endif
      end else begin
        shift_reg <= shift_next;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: instance A is 8-bit/1-stop/depth 4, instance B is 7-bit/2-stop.
// Every line bit is checked on every clock; define UART_TX_PARITY_EN to add the parity cases.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_A = 4 * (1 + 8 + PAR + 1);

  logic       CLK;
  logic       RST_N;
  logic [7:0] in_a;
  logic       valid_a, ready_a, out_a, busy_a;
  logic [2:0] level_a;
  logic [6:0] in_b;
  logic       valid_b, ready_b, out_b, busy_b;
  logic [4:0] level_b;
  logic       podd_a;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_fifo #(
    .DATA_WIDTH(8), .STOP_BITS(1), .COUNT_WIDTH(4), .COUNT_MAX(3), .FIFO_DEPTH_LOG2(2)
  ) dut_a (
    .CLK(CLK), .RST_N(RST_N), .in(in_a), .valid(valid_a), .ready(ready_a),
    .out(out_a), .busy(busy_a), .level(level_a)
`ifdef UART_TX_PARITY_EN
    , .parity_odd(podd_a)
`endif
  );

  uart_tx_fifo #(
    .DATA_WIDTH(7), .STOP_BITS(2), .COUNT_WIDTH(4), .COUNT_MAX(3), .FIFO_DEPTH_LOG2(4)
  ) dut_b (
    .CLK(CLK), .RST_N(RST_N), .in(in_b), .valid(valid_b), .ready(ready_b),
    .out(out_b), .busy(busy_b), .level(level_b)
`ifdef UART_TX_PARITY_EN
    , .parity_odd(1'b0)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_start(input bit sel);
    int n = 0;
    while (((sel ? out_b : out_a) !== 1'b0) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk("start_seen", sel ? out_b : out_a, 0);
  endtask

  // Caller sits on the first negedge of the start bit; returns on the negedge after the frame.
  task automatic check_frame(input bit sel, input logic [7:0] d, input int nd, input int ns,
                             input bit podd);
    logic exp_bits[16];
    int   nb;
    int   errs0;
    logic p;
    errs0 = n_fail;
    exp_bits[0] = 1'b0;
    p = podd;
    for (int i = 0; i < nd; i++) begin
      exp_bits[1 + i] = d[i];
      p = p ^ d[i];
    end
    nb = 1 + nd;
    if (PAR != 0) begin
      exp_bits[nb] = p;
      nb++;
    end
    for (int i = 0; i < ns; i++) begin
      exp_bits[nb] = 1'b1;
      nb++;
    end
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < 4; c++) begin
        chk("frame_bit", sel ? out_b : out_a, exp_bits[b]);
        @(negedge CLK);
      end
    end
    $display("tx frame inst=%0d data=0x%02h periods=%0d errors=%0d", sel, d, nb, n_fail - errs0);
  endtask

  logic [7:0] words [6];
  int         idx;
  logic       rdy_prev;
  int         zeros;

  initial begin
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hC3;
    words[3] = 8'h3C; words[4] = 8'hFE; words[5] = 8'h99;
    in_a = '0; valid_a = 1'b0; in_b = '0; valid_b = 1'b0; podd_a = 1'b0;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    #1;
    chk("rst_out_a", out_a, 1);
    chk("rst_ready_a", ready_a, 1);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_level_a", level_a, 0);
    chk("rst_out_b", out_b, 1);
    chk("rst_level_b", level_b, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_out", out_a, 1);

    // Single 0x55 frame: latency, per-clock bit pattern, busy drop at end of stop.
    in_a = 8'h55; valid_a = 1'b1;
    @(negedge CLK);
    valid_a = 1'b0;
    chk("lat_out_hi", out_a, 1);
    chk("lat_level", level_a, 1);
    chk("lat_busy", busy_a, 1);
    @(negedge CLK);
    chk("lat_out_lo", out_a, 0);
    check_frame(0, 8'h55, 8, 1, 1'b0);
    chk("t1_busy_end", busy_a, 0);
    chk("t1_out_end", out_a, 1);
    repeat (3) @(negedge CLK);

    // Hold valid for six words against a depth-4 FIFO.
    idx = 0; rdy_prev = 1'b0;
    fork
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge CLK);
          if (valid_a && rdy_prev) idx++;
          if (idx < 6) begin
            valid_a = 1'b1;
            in_a    = words[idx];
          end else begin
            valid_a = 1'b0;
          end
          rdy_prev = ready_a;
        end
        chk("full_accepted", idx, 5);
        chk("full_level", level_a, 4);
        chk("full_ready", ready_a, 0);
        valid_a = 1'b0;
      end
      begin
        wait_start(0);
        for (int w = 0; w < 5; w++) check_frame(0, words[w], 8, 1, 1'b0);
      end
    join
    chk("t2_out_idle", out_a, 1);
    chk("t2_busy_end", busy_a, 0);
    chk("t2_level_end", level_a, 0);
    repeat (3) @(negedge CLK);

`ifdef UART_TX_PARITY_EN
    // Parity of 0x07 is 1: even mode sends 1, odd mode sends 0.
    for (int m = 0; m < 2; m++) begin
      podd_a = m[0];
      in_a = 8'h07; valid_a = 1'b1;
      @(negedge CLK);
      valid_a = 1'b0;
      wait_start(0);
      check_frame(0, 8'h07, 8, 1, m[0]);
      chk("par_busy_end", busy_a, 0);
    end
    podd_a = 1'b0;
    repeat (3) @(negedge CLK);
`endif

    // 7 data bits, 2 stop bits, two frames back to back.
    fork
      begin
        @(negedge CLK);
        in_b = 7'h7F; valid_b = 1'b1;
        @(negedge CLK);
        in_b = 7'h00;
        @(negedge CLK);
        valid_b = 1'b0;
      end
      begin
        wait_start(1);
        check_frame(1, 8'h7F, 7, 2, 1'b0);
        check_frame(1, 8'h00, 7, 2, 1'b0);
      end
    join
    chk("t4_busy_end", busy_b, 0);
    chk("t4_out_end", out_b, 1);
    repeat (3) @(negedge CLK);

    // Asynchronous reset in the middle of a data bit of a three-word burst.
    in_a = 8'h00; valid_a = 1'b1;
    repeat (3) @(negedge CLK);
    valid_a = 1'b0;
    repeat (9) @(negedge CLK);
    chk("mid_out", out_a, 0);
    chk("mid_level", level_a, 2);
    chk("mid_busy", busy_a, 1);
    #1 RST_N = 1'b0;
    #1;
    chk("arst_out", out_a, 1);
    chk("arst_level", level_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_ready", ready_a, 1);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rel_out", out_a, 1);
    in_a = 8'hA5; valid_a = 1'b1;
    @(negedge CLK);
    valid_a = 1'b0;
    wait_start(0);
    check_frame(0, 8'hA5, 8, 1, 1'b0);
    zeros = 0;
    for (int c = 0; c < 60; c++) begin
      if (out_a !== 1'b1) zeros++;
      @(negedge CLK);
    end
    chk("no_extra_frame", zeros, 0);
    chk("t5_level_end", level_a, 0);

    // Push lands on the pop edge at level 2.
    fork
      begin
        for (int c = 0; c <= FRAME_A + 2; c++) begin
          @(negedge CLK);
          if (c == 0) begin
            in_a = 8'h11; valid_a = 1'b1;
          end else if (c == 1) begin
            in_a = 8'h22;
          end else if (c == 2) begin
            in_a = 8'h33;
          end else if (c == 3) begin
            valid_a = 1'b0;
          end else if (c == FRAME_A + 1) begin
            chk("pp_level_before", level_a, 2);
            in_a = 8'h44; valid_a = 1'b1;
          end else if (c == FRAME_A + 2) begin
            valid_a = 1'b0;
            chk("pp_level_after", level_a, 2);
          end
        end
      end
      begin
        wait_start(0);
        check_frame(0, 8'h11, 8, 1, 1'b0);
        check_frame(0, 8'h22, 8, 1, 1'b0);
        check_frame(0, 8'h33, 8, 1, 1'b0);
        check_frame(0, 8'h44, 8, 1, 1'b0);
      end
    join
    chk("t6_busy_end", busy_a, 0);
    chk("t6_level_end", level_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
